// File: rtl/spi_pkg.sv
// Shared SPI types and sizing helpers.
// No logic; no latency.
// No flow control.
package spi_pkg;

    localparam int SPI_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        TAIL
    } spi_state_e;

    // Counter width able to hold div-1 (minimum 1 bit).
    function automatic int cnt_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Reloadable down-counter; tick_o is high while the count is zero.
// A reload followed by DIV-1 decrements gives a tick every DIV cycles.
// No flow control; load_i wins over counting.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int DIV = 4,
    parameter int W   = cnt_width(DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic tick_o
);

    localparam logic [W-1:0] RELOAD = W'(DIV - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = RELOAD;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = (count_q == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, 8-bit frames; hold_ss keeps ssel low between frames.
// Frame: busy for 17*CLK_DIV cycles, then a one-cycle done with rxData valid.
// start is accepted only when idle; requests while busy are dropped, never queued.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SPI_WIDTH-1:0] txData,
    input  logic                 hold_ss,
    output logic                 busy,
    output logic                 done,
    output logic [SPI_WIDTH-1:0] rxData,
    output logic                 sck,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 ssel
);

    spi_state_e           state_q, state_d;
    logic [SPI_WIDTH-1:0] tx_q, tx_d;
    logic [SPI_WIDTH-1:0] rx_q, rx_d;
    logic [SPI_WIDTH-1:0] rxdata_q, rxdata_d;
    logic [2:0]           bit_q, bit_d;
    logic                 sck_q, sck_d;
    logic                 mosi_q, mosi_d;
    logic                 ssel_q, ssel_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick;

    // Counter is held at reload in IDLE and reloads on every phase change.
    spi_clk_div #(.DIV(CLK_DIV)) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .load_i ((state_q == IDLE) || tick),
        .tick_o (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tx_q     <= '0;
            rx_q     <= '0;
            rxdata_q <= '0;
            bit_q    <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            ssel_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rxdata_q <= rxdata_d;
            bit_q    <= bit_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            ssel_q   <= ssel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !busy_q) state_d = LOW;
            LOW:     if (tick) state_d = HIGH;
            HIGH:    if (tick) state_d = (bit_q == 3'd0) ? TAIL : LOW;
            TAIL:    if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d     = tx_q;
        rx_d     = rx_q;
        rxdata_d = rxdata_q;
        bit_d    = bit_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        ssel_d   = ssel_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    tx_d   = txData;
                    bit_d  = 3'd7;
                    mosi_d = txData[SPI_WIDTH-1];
                    ssel_d = 1'b0;
                    busy_d = 1'b1;
                end
            end
            LOW: begin
                if (tick) begin
                    sck_d = 1'b1;
                    rx_d  = {rx_q[SPI_WIDTH-2:0], miso};
                end
            end
            HIGH: begin
                if (tick) begin
                    sck_d = 1'b0;
                    if (bit_q != 3'd0) begin
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[SPI_WIDTH-2];
                        bit_d  = bit_q - 3'd1;
                    end
                end
            end
            TAIL: begin
                if (tick) begin
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    rxdata_d = rx_q;
                    ssel_d   = ~hold_ss;
                    mosi_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign rxData = rxdata_q;
    assign sck    = sck_q;
    assign mosi   = mosi_q;
    assign ssel   = ssel_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: CLK_DIV=4 instance with loopback or 8'h3C slave model, CLK_DIV=1 instance with miso tied high.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start4 = 1'b0, hold4 = 1'b0;
    logic [7:0] txData4 = 8'h00;
    logic       busy4, done4, sck4, mosi4, miso4, ssel4;
    logic [7:0] rxData4;

    logic       start1 = 1'b0;
    logic [7:0] txData1 = 8'h00;
    logic       busy1, done1, sck1, mosi1, ssel1;
    logic [7:0] rxData1;

    bit         loop = 1'b1;
    logic [7:0] s_tx = 8'h3C, s_rx = 8'h00;
    int         s_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] slv_q[$];

    int total = 0, passed = 0;

    assign miso4 = loop ? mosi4 : s_tx[7];

    spi_master #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start4), .txData(txData4), .hold_ss(hold4),
        .busy(busy4), .done(done4), .rxData(rxData4), .sck(sck4), .mosi(mosi4),
        .miso(miso4), .ssel(ssel4)
    );

    spi_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .txData(txData1), .hold_ss(1'b0),
        .busy(busy1), .done(done1), .rxData(rxData1), .sck(sck1), .mosi(mosi1),
        .miso(1'b1), .ssel(ssel1)
    );

    // Monitors, slave model and protocol checker, all sampled on the falling edge.
    logic sck4_p = 1'b0, mosi4_p = 1'b0, ssel4_p = 1'b1, done4_p = 1'b0;
    logic sck1_p = 1'b0, mosi1_p = 1'b0, done1_p = 1'b0;
    int   edge_cnt4 = 0, busy_cnt4 = 0, done_cnt4 = 0, ssel_rise4 = 0;
    logic [7:0] hist4 = 8'h00, hist1 = 8'h00;
    int   edge_cnt1 = 0, busy_cnt1 = 0, mosi_hi1 = 0, gap_bad1 = 0, last_rise1 = -1;
    int   cyc = 0, proto_err = 0;

    always @(negedge clk) begin
        cyc++;
        if (sck4 && !sck4_p) begin
            edge_cnt4++;
            hist4 = {hist4[6:0], mosi4};
        end
        if (busy4) busy_cnt4++;
        if (done4) done_cnt4++;
        if (ssel4 && !ssel4_p) ssel_rise4++;
        if (rst) begin
            s_tx  = 8'h3C;
            s_cnt = 0;
        end else if (sck4 && !sck4_p) begin
            s_rx = {s_rx[6:0], mosi4};
            s_cnt++;
            if (s_cnt == 8) begin
                slv_q.push_back(s_rx);
                s_cnt = 0;
                s_tx  = 8'h3C;
            end
        end else if (!sck4 && sck4_p && s_cnt != 0) begin
            s_tx = s_tx << 1;
        end

        if (sck1 && !sck1_p) begin
            edge_cnt1++;
            hist1 = {hist1[6:0], mosi1};
            if (last_rise1 >= 0 && cyc - last_rise1 != 2) gap_bad1++;
            last_rise1 = cyc;
        end
        if (busy1) busy_cnt1++;
        if (mosi1) mosi_hi1++;

        if (mosi4 !== mosi4_p && sck4 !== 1'b0) proto_err++;
        if (ssel4 === 1'b1 && sck4 !== 1'b0) proto_err++;
        if (done4 && done4_p) proto_err++;
        if (mosi1 !== mosi1_p && sck1 !== 1'b0) proto_err++;
        if (ssel1 === 1'b1 && sck1 !== 1'b0) proto_err++;
        if (done1 && done1_p) proto_err++;

        sck4_p = sck4; mosi4_p = mosi4; ssel4_p = ssel4; done4_p = done4;
        sck1_p = sck1; mosi1_p = mosi1; done1_p = done1;
    end

    task automatic issue4(input logic [7:0] tx, input logic hold);
        txData4   = tx;
        hold4     = hold;
        start4    = 1'b1;
        busy_cnt4 = 0;
        edge_cnt4 = 0;
        hist4     = 8'h00;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic wait_done4(output bit to);
        int n = 0;
        while (done4 !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        to = (done4 !== 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (sck4 !== 1'b0) $display("FAIL rst_sck: got %b want 0", sck4); else passed++;
        total++; if (mosi4 !== 1'b0) $display("FAIL rst_mosi: got %b want 0", mosi4); else passed++;
        total++; if (ssel4 !== 1'b1) $display("FAIL rst_ssel: got %b want 1", ssel4); else passed++;
        total++; if (busy4 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy4); else passed++;
        total++; if (done4 !== 1'b0) $display("FAIL rst_done: got %b want 0", done4); else passed++;
        total++; if (rxData4 !== 8'h00) $display("FAIL rst_rx: got %h want 00", rxData4); else passed++;
        total++;
        if ({sck1, mosi1, ssel1, busy1, done1, rxData1} !== {5'b00100, 8'h00})
            $display("FAIL rst_div1: got %b want 0010000000000", {sck1, mosi1, ssel1, busy1, done1, rxData1});
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_loopback();
        bit to;
        logic [7:0] e, got;
        loop = 1'b1;
        slv_q.delete();
        exp_q.push_back(8'hA5);
        issue4(8'hA5, 1'b0);
        wait_done4(to);
        e = exp_q.pop_front();
        total++; if (to) $display("FAIL lb_timeout: done never seen"); else passed++;
        total++; if (busy_cnt4 !== 68) $display("FAIL lb_busy_len: got %0d want 68", busy_cnt4); else passed++;
        total++; if (edge_cnt4 !== 8) $display("FAIL lb_sck_edges: got %0d want 8", edge_cnt4); else passed++;
        total++; if (hist4 !== 8'hA5) $display("FAIL lb_mosi_seq: got %b want 10100101", hist4); else passed++;
        total++; if (rxData4 !== e) $display("FAIL lb_rx: got %h want %h", rxData4, e); else passed++;
        total++; if (ssel4 !== 1'b1) $display("FAIL lb_ssel_release: got %b want 1", ssel4); else passed++;
        @(negedge clk);
        total++; if (done4 !== 1'b0 || rxData4 !== e) $display("FAIL lb_after_done: done %b rx %h want 0 %h", done4, rxData4, e); else passed++;
        got = (slv_q.size() != 0) ? slv_q.pop_front() : 8'hxx;
        total++; if (got !== 8'hA5) $display("FAIL lb_slave_rx: got %h want a5", got); else passed++;
    endtask

    task automatic test_back_to_back();
        bit to;
        int r0;
        logic [7:0] e, got;
        loop = 1'b0;
        slv_q.delete();
        @(negedge clk);
        r0 = ssel_rise4;
        exp_q.push_back(8'h3C);
        issue4(8'hFF, 1'b1);
        wait_done4(to);
        e = exp_q.pop_front();
        total++; if (to) $display("FAIL b2b_timeout1: done never seen"); else passed++;
        total++; if (rxData4 !== e) $display("FAIL b2b_rx1: got %h want %h", rxData4, e); else passed++;
        total++; if (ssel4 !== 1'b0) $display("FAIL b2b_ssel_hold1: got %b want 0", ssel4); else passed++;
        exp_q.push_back(8'h3C);
        issue4(8'h00, 1'b1);
        wait_done4(to);
        e = exp_q.pop_front();
        total++; if (to) $display("FAIL b2b_timeout2: done never seen"); else passed++;
        total++; if (rxData4 !== e) $display("FAIL b2b_rx2: got %h want %h", rxData4, e); else passed++;
        total++; if (busy_cnt4 !== 68) $display("FAIL b2b_busy_len2: got %0d want 68", busy_cnt4); else passed++;
        total++; if (ssel_rise4 !== r0) $display("FAIL b2b_no_gap: got %0d ssel rises want 0", ssel_rise4 - r0); else passed++;
        got = (slv_q.size() != 0) ? slv_q.pop_front() : 8'hxx;
        total++; if (got !== 8'hFF) $display("FAIL b2b_slave1: got %h want ff", got); else passed++;
        got = (slv_q.size() != 0) ? slv_q.pop_front() : 8'hxx;
        total++; if (got !== 8'h00) $display("FAIL b2b_slave2: got %h want 00", got); else passed++;
        repeat (20) @(negedge clk);
        total++; if (ssel4 !== 1'b0) $display("FAIL b2b_ssel_stays_low: got %b want 0", ssel4); else passed++;
    endtask

    task automatic test_start_while_busy();
        bit to;
        int d0, n;
        logic [7:0] e;
        loop = 1'b1;
        @(negedge clk);
        d0 = done_cnt4;
        exp_q.push_back(8'hC3);
        issue4(8'hC3, 1'b0);
        n = 0;
        while (edge_cnt4 < 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        total++; if (edge_cnt4 !== 5) $display("FAIL swb_reach_bit3: got %0d edges want 5", edge_cnt4); else passed++;
        txData4 = 8'h00;
        start4  = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(to);
        e = exp_q.pop_front();
        total++; if (to) $display("FAIL swb_timeout: done never seen"); else passed++;
        total++; if (rxData4 !== e) $display("FAIL swb_rx: got %h want %h", rxData4, e); else passed++;
        total++; if (hist4 !== 8'hC3) $display("FAIL swb_mosi_seq: got %h want c3", hist4); else passed++;
        total++; if (busy_cnt4 !== 68) $display("FAIL swb_busy_len: got %0d want 68", busy_cnt4); else passed++;
        repeat (80) @(negedge clk);
        total++; if (done_cnt4 - d0 !== 1) $display("FAIL swb_done_count: got %0d want 1", done_cnt4 - d0); else passed++;
        total++; if (busy4 !== 1'b0) $display("FAIL swb_not_queued: busy %b want 0", busy4); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        int d0, n;
        logic [7:0] e;
        loop = 1'b1;
        @(negedge clk);
        issue4(8'hF0, 1'b0);
        n = 0;
        while (!(edge_cnt4 >= 3 && sck4 === 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        total++; if (sck4 !== 1'b1) $display("FAIL rmf_reach_high: sck %b want 1", sck4); else passed++;
        d0 = done_cnt4;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({sck4, ssel4, busy4, mosi4, done4} !== 5'b01000)
            $display("FAIL rmf_abort: sck/ssel/busy/mosi/done got %b want 01000", {sck4, ssel4, busy4, mosi4, done4});
        else passed++;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (done_cnt4 !== d0) $display("FAIL rmf_no_done: got %0d pulses want 0", done_cnt4 - d0); else passed++;
        exp_q.push_back(8'h81);
        issue4(8'h81, 1'b0);
        wait_done4(to);
        e = exp_q.pop_front();
        total++; if (to) $display("FAIL rmf_timeout: done never seen"); else passed++;
        total++; if (rxData4 !== e) $display("FAIL rmf_rx: got %h want %h", rxData4, e); else passed++;
        total++; if (busy_cnt4 !== 68) $display("FAIL rmf_busy_len: got %0d want 68", busy_cnt4); else passed++;
    endtask

    task automatic test_clk_div1();
        int n;
        logic [7:0] e;
        @(negedge clk);
        busy_cnt1 = 0; edge_cnt1 = 0; hist1 = 8'h00; mosi_hi1 = 0; gap_bad1 = 0; last_rise1 = -1;
        exp_q.push_back(8'hFF);
        txData1 = 8'h01;
        start1  = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (done1 !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        total++; if (done1 !== 1'b1) $display("FAIL d1_timeout: done never seen"); else passed++;
        total++; if (busy_cnt1 !== 17) $display("FAIL d1_busy_len: got %0d want 17", busy_cnt1); else passed++;
        total++; if (edge_cnt1 !== 8) $display("FAIL d1_sck_edges: got %0d want 8", edge_cnt1); else passed++;
        total++; if (gap_bad1 !== 0) $display("FAIL d1_sck_period: got %0d bad gaps want 0", gap_bad1); else passed++;
        total++; if (hist1 !== 8'h01) $display("FAIL d1_mosi_seq: got %b want 00000001", hist1); else passed++;
        total++; if (mosi_hi1 !== 3) $display("FAIL d1_mosi_high_cycles: got %0d want 3", mosi_hi1); else passed++;
        total++; if (rxData1 !== e) $display("FAIL d1_rx: got %h want %h", rxData1, e); else passed++;
    endtask

    task automatic test_protocol();
        total++; if (proto_err !== 0) $display("FAIL protocol: got %0d violations want 0", proto_err); else passed++;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_frame();
        test_clk_div1();
        repeat (5) @(negedge clk);
        test_protocol();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 master (CPOL=0, CPHA=0), MSB first, 8-bit frames, active-low slave select.
- Peer of the team's SPI_slave: drives sck/mosi/ssel and samples miso.
- Sits between on-chip logic (start/txData/rxData handshake) and the external SPI pins.
- Supports back-to-back frames with ssel held low via hold_ss.

Parameters:
- CLK_DIV, 4: clk cycles per sck half-period. Legal range 1..255; values below 1 are illegal.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a frame; accepted only when busy=0.
- txData  in  8  byte to send; latched on the accepting cycle.
- hold_ss  in  1  sampled at frame end; 1 keeps ssel low after the frame.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse; rxData is valid in the same cycle.
- rxData  out  8  last received byte; held until the next done.
- sck  out  1  SPI clock; idles 0.
- mosi  out  1  master out; changes only while sck=0.
- miso  in  1  slave out; sampled on sck rising edges.
- ssel  out  1  slave select, active-low.

Behaviour:
- Reset value of every output: sck=0, mosi=0, ssel=1, busy=0, done=0, rxData=8'h00. Reset mid-frame aborts the frame the next cycle with no done pulse.
- States:
  - IDLE: ssel=1 or 0, depending on the previous hold_ss.
  - LOW: sck=0, CLK_DIV cycles.
  - HIGH: sck=1, CLK_DIV cycles.
  - TAIL: sck=0, CLK_DIV cycles.
- Half-period counter: reloads on every state entry.
- Bit counter: 3 bits, counts 7 down to 0.
- Frame start: IDLE with start=1 and busy=0 moves to LOW. On that edge:
  - latch the shift register from txData; set bit index to 7;
  - drive mosi=txData[7], ssel=0, busy=1.
- LOW to HIGH: after CLK_DIV cycles, set sck=1 and shift miso into rx_shift LSB on the same edge.
- HIGH to LOW (bit index > 0): after CLK_DIV cycles, set sck=0, shift tx left, set mosi to the next bit, decrement the bit index.
- HIGH to TAIL (bit index = 0): after CLK_DIV cycles, set sck=0. mosi holds the last bit.
- TAIL to IDLE: after CLK_DIV cycles:
  - busy=0, done=1 for 1 cycle, rxData=rx_shift;
  - ssel=~hold_ss sampled at this edge;
  - mosi=0.
- Frame length: busy high for exactly 17*CLK_DIV cycles. The done cycle is the first cycle with busy=0.
- Sampling: the first miso sample is the MSB, so rxData[7] is the first bit received.
- start while busy=1: ignored, not queued.
- start during the done cycle: accepted; the next frame begins the following cycle.
  - If ssel is already low (hold_ss=1), no deselect gap occurs.
  - Otherwise ssel goes 1 for the done cycle, then 0 again.
- hold_ss=1 with no further start: ssel stays low indefinitely until a later frame ends with hold_ss=0, or rst.
- txData changes after acceptance: no effect on the current frame.
- sck glitch-free: registered output, exactly 8 rising edges per frame.

Decomposition:
- Package spi_pkg:
  - SPI_WIDTH=8;
  - state enum {IDLE, LOW, HIGH, TAIL};
  - CLK_DIV width function (clog2).
- Sub-module spi_clk_div: reloadable down-counter with a tick output when the count reaches 0. Reused by future SPI blocks.
- Everything else stays in one FSM module.

Test Plan:
- Loopback (miso=mosi), CLK_DIV=4, txData=8'hA5, hold_ss=0:
  - exactly 8 sck rising edges; mosi sequence 1,0,1,0,0,1,0,1;
  - done after 68 busy cycles; rxData=8'hA5; ssel returns 1.
- Bench slave model returning 8'h3C, master sends 8'hFF then 8'h00 back-to-back with hold_ss=1 (start asserted in the done cycle):
  - ssel never rises between the frames;
  - both rxData=8'h3C;
  - slave model receives 8'hFF then 8'h00.
- start pulsed while busy, mid-frame at bit 3: ignored; exactly one done; frame content unaltered.
- rst asserted during a HIGH phase: next cycle sck=0, ssel=1, busy=0, mosi=0, no done pulse. A subsequent frame with txData=8'h81 completes correctly.
- CLK_DIV=1, txData=8'h01, miso tied 1:
  - sck period is 2 clk cycles; busy lasts 17 cycles;
  - rxData=8'hFF; mosi high only during the last bit.
- Protocol checker assertions: mosi changes only while sck=0; sck=0 whenever ssel=1; done is never high for 2 consecutive cycles.
